// File: rtl/time_of_day_counter_param.sv
// 24-hour hh:mm time-of-day counter.
// A prescaler divides the clock down to one-minute steps. Several preset
// sources can load the time; the lowest-index requesting source wins. An
// alarm comparator and single-cycle status pulses accompany each counted
// advance.
module time_of_day_counter_param #(
  parameter int TICKS_PER_MIN = 64,
  parameter int NUM_LOAD      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_LOAD-1:0]     load,
  input  logic [5*NUM_LOAD-1:0]   load_ore,
  input  logic [6*NUM_LOAD-1:0]   load_minute,
  input  logic                    alarm_en,
  input  logic [4:0]              alarm_ore,
  input  logic [5:0]              alarm_minute,
  output logic [4:0]              out_ore,
  output logic [5:0]              out_minute,
  output logic                    minute_tick,
  output logic                    day_wrap,
  output logic                    alarm_hit,
  output logic                    load_err
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MIN - 1);

  logic [PW-1:0] presc;

  // Selected preset source
  logic       load_any;
  logic [4:0] sel_ore;
  logic [5:0] sel_minute;
  logic       sel_valid;

  // Time one minute ahead of the current value
  logic [4:0] nxt_ore;
  logic [5:0] nxt_minute;
  logic       nxt_wrap;

  logic       alarm_valid;
  logic       alarm_match;
  logic       presc_last;

  // Pick the lowest-index requesting source; scanning downward lets the
  // lowest index overwrite any higher one.
  always_comb begin
    load_any   = 1'b0;
    sel_ore    = 5'd0;
    sel_minute = 6'd0;
    for (int i = NUM_LOAD - 1; i >= 0; i--) begin
      if (load[i]) begin
        load_any   = 1'b1;
        sel_ore    = load_ore[5*i +: 5];
        sel_minute = load_minute[6*i +: 6];
      end
    end
    sel_valid = (sel_ore <= 5'd23) && (sel_minute <= 6'd59);
  end

  // Next-minute arithmetic with hour carry and midnight rollover.
  always_comb begin
    nxt_ore    = out_ore;
    nxt_minute = out_minute + 6'd1;
    nxt_wrap   = 1'b0;
    if (out_minute == 6'd59) begin
      nxt_minute = 6'd0;
      if (out_ore == 5'd23) begin
        nxt_ore  = 5'd0;
        nxt_wrap = 1'b1;
      end else begin
        nxt_ore = out_ore + 5'd1;
      end
    end
  end

  // Alarm compare against the time about to appear; an out-of-range alarm
  // setting can never equal a legal time, the explicit check keeps intent clear.
  always_comb begin
    alarm_valid = (alarm_ore <= 5'd23) && (alarm_minute <= 6'd59);
    alarm_match = alarm_en && alarm_valid &&
                  (nxt_ore == alarm_ore) && (nxt_minute == alarm_minute);
    presc_last  = (presc == PRESC_MAX);
  end

  // Time, prescaler and pulse registers: reset > load > count > hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_ore     <= 5'd0;
      out_minute  <= 6'd0;
      presc       <= '0;
      minute_tick <= 1'b0;
      day_wrap    <= 1'b0;
      alarm_hit   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      minute_tick <= 1'b0;
      day_wrap    <= 1'b0;
      alarm_hit   <= 1'b0;
      load_err    <= 1'b0;
      if (load_any) begin
        if (sel_valid) begin
          out_ore    <= sel_ore;
          out_minute <= sel_minute;
          presc      <= '0;
        end else begin
          // Rejected load: time holds, prescaler keeps its normal cadence.
          load_err <= 1'b1;
          if (enable) begin
            presc <= presc_last ? '0 : presc + 1'b1;
          end
        end
      end else if (enable) begin
        if (presc_last) begin
          presc       <= '0;
          out_ore     <= nxt_ore;
          out_minute  <= nxt_minute;
          minute_tick <= 1'b1;
          day_wrap    <= nxt_wrap;
          alarm_hit   <= alarm_match;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_of_day_counter_param.sv
// Bench for time_of_day_counter_param: directed scenarios followed by random
// traffic, all checked every cycle against a minute-of-day reference model.
module tb_time_of_day_counter_param;

  localparam int T  = 64;
  localparam int NL = 2;

  // Clock / reset block
  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [NL-1:0]   load;
  logic [5*NL-1:0] load_ore;
  logic [6*NL-1:0] load_minute;
  logic            alarm_en;
  logic [4:0]      alarm_ore;
  logic [5:0]      alarm_minute;
  logic [4:0]      out_ore;
  logic [5:0]      out_minute;
  logic            minute_tick;
  logic            day_wrap;
  logic            alarm_hit;
  logic            load_err;

  always #5 clock = ~clock;

  time_of_day_counter_param #(.TICKS_PER_MIN(T), .NUM_LOAD(NL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_ore(load_ore), .load_minute(load_minute),
    .alarm_en(alarm_en), .alarm_ore(alarm_ore), .alarm_minute(alarm_minute),
    .out_ore(out_ore), .out_minute(out_minute), .minute_tick(minute_tick),
    .day_wrap(day_wrap), .alarm_hit(alarm_hit), .load_err(load_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time as minutes since midnight, progress as a count of
  // enabled cycles since the last restart.
  int m_time = 0;
  int m_cnt  = 0;
  bit e_tick, e_wrap, e_hit, e_err;

  task automatic model_step();
    int h, mi;
    bit found;
    e_tick = 0; e_wrap = 0; e_hit = 0; e_err = 0;
    found = 0; h = 0; mi = 0;
    if (reset) begin
      m_time = 0;
      m_cnt  = 0;
      return;
    end
    for (int i = 0; i < NL; i++) begin
      if (!found && load[i]) begin
        found = 1;
        h  = int'(load_ore[5*i +: 5]);
        mi = int'(load_minute[6*i +: 6]);
      end
    end
    if (found) begin
      if (h <= 23 && mi <= 59) begin
        m_time = h * 60 + mi;
        m_cnt  = 0;
      end else begin
        e_err = 1;
        if (enable) m_cnt = (m_cnt + 1) % T;
      end
    end else if (enable) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == T) begin
        m_cnt  = 0;
        m_time = (m_time + 1) % 1440;
        e_tick = 1;
        e_wrap = (m_time == 0);
        e_hit  = alarm_en && int'(alarm_ore) <= 23 && int'(alarm_minute) <= 59 &&
                 (int'(alarm_ore) * 60 + int'(alarm_minute) == m_time);
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: one clock edge, advance the model, then compare every output.
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check("ore",         32'(out_ore),     32'(m_time / 60));
    check("minute",      32'(out_minute),  32'(m_time % 60));
    check("minute_tick", 32'(minute_tick), 32'(e_tick));
    check("day_wrap",    32'(day_wrap),    32'(e_wrap));
    check("alarm_hit",   32'(alarm_hit),   32'(e_hit));
    check("load_err",    32'(load_err),    32'(e_err));
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic set_src(int i, int h, int mi);
    load_ore[5*i +: 5]    = 5'(h);
    load_minute[6*i +: 6] = 6'(mi);
  endtask

  initial begin
    reset = 1; enable = 0; load = '0; load_ore = '0; load_minute = '0;
    alarm_en = 0; alarm_ore = '0; alarm_minute = '0;
    step();
    check("reset_time", {21'd0, out_ore, out_minute}, 32'd0);
    reset = 0; enable = 1;

    // Counting from reset: first advance after exactly T cycles
    run(T - 1);
    check("t1_no_tick_early", 32'(minute_tick), 32'd0);
    step();
    check("t1_0001", {21'd0, out_ore, out_minute}, {21'd0, 5'd0, 6'd1});
    check("t1_tick", 32'(minute_tick), 32'd1);
    run(T);
    check("t1_0002", 32'(out_minute), 32'd2);

    // Midnight rollover
    set_src(0, 23, 59); load = 2'b01;
    step();
    load = 2'b00;
    run(T);
    check("t2_time", {21'd0, out_ore, out_minute}, 32'd0);
    check("t2_tick", 32'(minute_tick), 32'd1);
    check("t2_wrap", 32'(day_wrap), 32'd1);

    // Priority and rejected load
    set_src(0, 10, 15); set_src(1, 5, 30); load = 2'b11;
    step();
    check("t3_prio", {21'd0, out_ore, out_minute}, {21'd0, 5'd10, 6'd15});
    set_src(1, 24, 0); load = 2'b10;
    step();
    check("t3_err", 32'(load_err), 32'd1);
    check("t3_hold", {21'd0, out_ore, out_minute}, {21'd0, 5'd10, 6'd15});
    load = 2'b00;
    step();
    check("t3_err_pulse", 32'(load_err), 32'd0);

    // Alarm from counting, not from loading
    alarm_en = 1; alarm_ore = 5'd7; alarm_minute = 6'd30;
    set_src(0, 7, 29); load = 2'b01;
    step();
    load = 2'b00;
    run(T);
    check("t4_hit", 32'(alarm_hit), 32'd1);
    step();
    check("t4_hit_pulse", 32'(alarm_hit), 32'd0);
    set_src(0, 7, 30); load = 2'b01;
    step();
    check("t4_load_no_hit", 32'(alarm_hit), 32'd0);
    load = 2'b00; alarm_en = 0;

    // Pause mid-minute and resume
    set_src(0, 3, 3); load = 2'b01;
    step();
    load = 2'b00;
    run(40);
    enable = 0;
    run(100);
    check("t5_frozen", {21'd0, out_ore, out_minute}, {21'd0, 5'd3, 6'd3});
    enable = 1;
    run(23);
    check("t5_no_tick", 32'(minute_tick), 32'd0);
    step();
    check("t5_tick", 32'(minute_tick), 32'd1);
    check("t5_time", 32'(out_minute), 32'd4);

    // Reset mid-count discards progress
    set_src(0, 12, 34); load = 2'b01;
    step();
    load = 2'b00;
    run(50);
    reset = 1;
    step();
    check("t6_reset", {21'd0, out_ore, out_minute}, 32'd0);
    reset = 0;
    run(T - 1);
    check("t6_no_tick", 32'(minute_tick), 32'd0);
    step();
    check("t6_tick", 32'(minute_tick), 32'd1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int nxt;
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NL; i++) begin
        load[i] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 3) == 0) set_src(i, $urandom_range(0, 31), $urandom_range(0, 63));
        else if ($urandom_range(0, 1) == 0) set_src(i, 23, $urandom_range(55, 59));
        else set_src(i, $urandom_range(0, 23), $urandom_range(0, 59));
      end
      alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          nxt = (m_time + 1) % 1440;
          alarm_ore    = 5'(nxt / 60);
          alarm_minute = 6'(nxt % 60);
        end else begin
          alarm_ore    = 5'($urandom_range(0, 31));
          alarm_minute = 6'($urandom_range(0, 63));
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
